// File: rtl/spectrum_store.sv
// spectrum_store: double-buffered per-bin spectrum memory with peak-hold and decay.
//
// A streamed frame of bin powers is written into the back amplitude bank while the
// display reads the front bank. A completed frame is swapped to the front only on a
// video frame boundary, so the displayed trace never tears. A shared peak RAM is
// updated by read-modify-write for every written bin (hold, optional decay, or clear).
//
// Ports:
//   i_pixClk      pixel clock, the only clock
//   i_rst_n       synchronous reset, active low
//   i_binValid    write beat valid
//   i_binData     bin power in dB
//   i_binLast     last bin of a frame, qualified by the handshake
//   o_binReady    store accepts a beat
//   i_peakClr     pulse: the next written frame reinitialises all peaks
//   i_frameStart  pulse at the start of each video frame
//   i_rdAddr      display bin address
//   o_amplitude   front-bank amplitude at the registered i_rdAddr (1-cycle latency)
//   o_peak        held peak at the registered i_rdAddr (1-cycle latency)
//   o_overrun     sticky: a frame had more than BINS beats
module spectrum_store #(
  parameter int unsigned BINS       = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DECAY_DIV  = 8,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic              i_pixClk,
  input  logic              i_rst_n,
  input  logic              i_binValid,
  input  logic [7:0]        i_binData,
  input  logic              i_binLast,
  output logic              o_binReady,
  input  logic              i_peakClr,
  input  logic              i_frameStart,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [7:0]        o_amplitude,
  output logic [7:0]        o_peak,
  output logic              o_overrun
);

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(BINS - 1);
  localparam logic [7:0]        DecayStep = 8'(DECAY_STEP);
  localparam logic [7:0]        DecayLast = 8'(DECAY_DIV - 1);

  logic [7:0] amp0_mem [BINS];
  logic [7:0] amp1_mem [BINS];
  logic [7:0] peak_mem [BINS];

  // Control state
  logic              bank_q, bank_d;       // 0: amp0 is front, amp1 is back
  logic              pending_q, pending_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              overrun_q, overrun_d;
  logic              full_q, full_d;       // bin BINS-1 written; further beats discarded
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        decay_cnt_q, decay_cnt_d;
  logic              decay_q, decay_d;
  logic              clear_q, clear_d;

  // Display read pipeline
  logic [ADDR_W-1:0] rd_addr_q;
  logic              out_en_q;
  logic [7:0]        amp_rd_q;
  logic [7:0]        peak_rd_q;

  // Peak read-modify-write pipeline (read at acceptance, write one cycle later)
  logic              pk_we_q;
  logic [ADDR_W-1:0] pk_addr_q;
  logic [7:0]        pk_data_q;
  logic              pk_clr_q;
  logic              pk_dec_q;
  logic [7:0]        pk_old_q;
  logic [7:0]        pk_decayed;
  logic [7:0]        pk_new;

  logic accept;
  logic beat_we;
  logic swap;

  assign accept  = i_binValid & ready_q;
  assign beat_we = accept & ~full_q;
  // A last beat accepted together with i_frameStart swaps on that same edge.
  assign swap    = i_frameStart & (pending_q | (accept & i_binLast));

  always_comb begin
    bank_d      = bank_q;
    pending_d   = pending_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    full_d      = full_q;
    wr_addr_d   = wr_addr_q;
    decay_cnt_d = decay_cnt_q;
    decay_d     = decay_q;
    clear_d     = clear_q;

    if (accept) begin
      if (full_q) begin
        overrun_d = 1'b1;
      end
      if (i_binLast) begin
        wr_addr_d = '0;
        full_d    = 1'b0;
        pending_d = 1'b1;
        clear_d   = 1'b0;
        decay_d   = 1'b0;
      end else if (wr_addr_q == LastAddr) begin
        full_d = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    // Arming wins over the end-of-frame disarm so a same-cycle request is not lost.
    if (i_peakClr) begin
      clear_d = 1'b1;
    end

    if (swap) begin
      bank_d    = ~bank_q;
      pending_d = 1'b0;
      valid_d   = 1'b1;
      if (decay_cnt_q == DecayLast) begin
        decay_cnt_d = '0;
        decay_d     = 1'b1;
      end else begin
        decay_cnt_d = decay_cnt_q + 8'd1;
      end
    end

    // Ready always drops for the cycle after a last beat, even if the swap was immediate.
    ready_d = ~pending_d & ~(accept & i_binLast);
  end

  always_ff @(posedge i_pixClk) begin
    if (!i_rst_n) begin
      bank_q      <= 1'b0;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
      full_q      <= 1'b0;
      wr_addr_q   <= '0;
      decay_cnt_q <= '0;
      decay_q     <= 1'b0;
      clear_q     <= 1'b1;
      rd_addr_q   <= '0;
      out_en_q    <= 1'b0;
      pk_we_q     <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
      full_q      <= full_d;
      wr_addr_q   <= wr_addr_d;
      decay_cnt_q <= decay_cnt_d;
      decay_q     <= decay_d;
      clear_q     <= clear_d;
      rd_addr_q   <= i_rdAddr;
      out_en_q    <= valid_q;
      pk_we_q     <= beat_we;
    end
  end

  always_comb begin
    pk_decayed = pk_old_q;
    if (pk_dec_q) begin
      pk_decayed = (pk_old_q > DecayStep) ? (pk_old_q - DecayStep) : 8'd0;
    end
    if (pk_clr_q) begin
      pk_new = pk_data_q;
    end else begin
      pk_new = (pk_data_q > pk_decayed) ? pk_data_q : pk_decayed;
    end
  end

  // Memories and data-path registers carry no reset; RAM contents survive reset.
  always_ff @(posedge i_pixClk) begin
    if (beat_we) begin
      if (bank_q) begin
        amp0_mem[wr_addr_q] <= i_binData;
      end else begin
        amp1_mem[wr_addr_q] <= i_binData;
      end
    end

    pk_addr_q <= wr_addr_q;
    pk_data_q <= i_binData;
    pk_clr_q  <= clear_q;
    pk_dec_q  <= decay_q;
    pk_old_q  <= peak_mem[wr_addr_q];
    if (pk_we_q) begin
      peak_mem[pk_addr_q] <= pk_new;
    end

    amp_rd_q  <= bank_q ? amp1_mem[rd_addr_q] : amp0_mem[rd_addr_q];
    peak_rd_q <= peak_mem[rd_addr_q];
  end

  assign o_binReady  = ready_q;
  assign o_overrun   = overrun_q;
  assign o_amplitude = out_en_q ? amp_rd_q : 8'd0;
  assign o_peak      = out_en_q ? peak_rd_q : 8'd0;

endmodule

// File: tb/tb_spectrum_store.sv
module tb_spectrum_store;

  localparam int BINS   = 1024;
  localparam int ADDR_W = 10;
  localparam int DIV    = 2;
  localparam int STEP   = 1;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_binValid;
  logic [7:0]        i_binData;
  logic              i_binLast;
  logic              o_binReady;
  logic              i_peakClr;
  logic              i_frameStart;
  logic [ADDR_W-1:0] i_rdAddr;
  logic [7:0]        o_amplitude;
  logic [7:0]        o_peak;
  logic              o_overrun;

  always #5 clk = ~clk;

  spectrum_store #(
    .BINS      (BINS),
    .ADDR_W    (ADDR_W),
    .DECAY_DIV (DIV),
    .DECAY_STEP(STEP)
  ) dut (
    .i_pixClk    (clk),
    .i_rst_n     (i_rst_n),
    .i_binValid  (i_binValid),
    .i_binData   (i_binData),
    .i_binLast   (i_binLast),
    .o_binReady  (o_binReady),
    .i_peakClr   (i_peakClr),
    .i_frameStart(i_frameStart),
    .i_rdAddr    (i_rdAddr),
    .o_amplitude (o_amplitude),
    .o_peak      (o_peak),
    .o_overrun   (o_overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame-level view of banks, peaks and flags
  logic [7:0] m_amp [2][BINS];
  logic [7:0] m_peak[BINS];
  int m_bank, m_valid, m_pending, m_clear, m_decay, m_cnt, m_overrun;
  logic [7:0] fq[$];

  function automatic void m_reset();
    m_bank = 0; m_valid = 0; m_pending = 0; m_clear = 1;
    m_decay = 0; m_cnt = 0; m_overrun = 0;
  endfunction

  function automatic void m_frame(input bit with_last);
    int back = 1 - m_bank;
    for (int i = 0; i < fq.size(); i++) begin
      if (i < BINS) begin
        int old = m_peak[i];
        int dec = old;
        int d   = fq[i];
        if (m_decay != 0) dec = (old > STEP) ? old - STEP : 0;
        m_amp[back][i] = fq[i];
        m_peak[i] = (m_clear != 0) ? fq[i] : 8'((d > dec) ? d : dec);
      end else begin
        m_overrun = 1;
      end
    end
    if (with_last) begin
      m_clear = 0; m_decay = 0; m_pending = 1;
    end
  endfunction

  function automatic void m_swap();
    if (m_pending != 0) begin
      m_bank = 1 - m_bank; m_pending = 0; m_valid = 1;
      if (m_cnt == DIV - 1) begin
        m_cnt = 0; m_decay = 1;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  // Scoreboard: reads push expectations, monitor pops two edges later
  typedef struct {
    int         addr;
    logic [7:0] amp;
    logic [7:0] pk;
  } exp_t;
  exp_t sbq[$];
  bit rd_req = 1'b0;
  bit req_d1 = 1'b0;
  bit req_d2 = 1'b0;

  always @(posedge clk) begin
    req_d1 <= rd_req;
    req_d2 <= req_d1;
  end

  always @(negedge clk) begin
    if (req_d2) begin : mon
      exp_t e;
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("amp[%0d]", e.addr), {24'd0, o_amplitude}, {24'd0, e.amp});
        chk($sformatf("peak[%0d]", e.addr), {24'd0, o_peak}, {24'd0, e.pk});
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a);
    exp_t e;
    e.addr = a;
    e.amp  = (m_valid != 0) ? m_amp[m_bank][a] : 8'd0;
    e.pk   = (m_valid != 0) ? m_peak[a] : 8'd0;
    sbq.push_back(e);
    i_rdAddr = ADDR_W'(a);
    rd_req   = 1'b1;
    sync();
    rd_req   = 1'b0;
  endtask

  task automatic rd_rand(input int n);
    for (int i = 0; i < n; i++) rd($urandom_range(0, BINS - 1));
  endtask

  task automatic drain();
    repeat (3) sync();
  endtask

  // kind 0: constant val, 1: bin index, 2: random
  task automatic make_frame(input int n, input int kind, input logic [7:0] val);
    fq.delete();
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       fq.push_back(val);
        1:       fq.push_back(8'(i));
        default: fq.push_back(8'($urandom));
      endcase
    end
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (o_binReady) break;
      n++;
      if (n > 2000) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    sync();
  endtask

  task automatic send_frame(input bit with_last, input bit fs_on_last);
    for (int i = 0; i < fq.size(); i++) begin
      i_binValid = 1'b1;
      i_binData  = fq[i];
      i_binLast  = with_last && (i == fq.size() - 1);
      if (i_binLast && fs_on_last) i_frameStart = 1'b1;
      wait_accept();
      i_frameStart = 1'b0;
    end
    i_binValid = 1'b0;
    i_binLast  = 1'b0;
    m_frame(with_last);
    if (fs_on_last) m_swap();
  endtask

  task automatic frame_start();
    i_frameStart = 1'b1;
    sync();
    i_frameStart = 1'b0;
    m_swap();
  endtask

  task automatic pulse_clr();
    i_peakClr = 1'b1;
    sync();
    i_peakClr = 1'b0;
    m_clear = 1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_amp"}, {24'd0, o_amplitude}, 0);
    chk({tag, "_peak"}, {24'd0, o_peak}, 0);
    chk({tag, "_ready"}, {31'd0, o_binReady}, 0);
    chk({tag, "_overrun"}, {31'd0, o_overrun}, 0);
    sync();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_binValid = 1'b0; i_binData = '0; i_binLast = 1'b0;
    i_peakClr = 1'b0; i_frameStart = 1'b0; i_rdAddr = '0;
    m_reset();
    repeat (3) sync();
    chk_reset_outputs("rst");

    // Release: ready rises only after the first edge with reset high
    i_rst_n = 1'b1;
    @(negedge clk);
    chk("ready_pre_release", {31'd0, o_binReady}, 0);
    sync();
    @(negedge clk);
    chk("ready_post_release", {31'd0, o_binReady}, 1);
    sync();

    // Ramp frame; front bank stays blank until the swap
    make_frame(BINS, 1, 8'd0);
    send_frame(1, 0);
    rd(37);
    drain();
    frame_start();
    rd(37);
    rd_rand(5);
    drain();

    // Constant frame with valid held high past last
    make_frame(BINS, 0, 8'h10);
    send_frame(1, 0);
    @(negedge clk);
    chk("ready_after_last", {31'd0, o_binReady}, 0);
    sync();
    i_binValid = 1'b1;
    i_binData  = 8'hEE;
    repeat (8) begin
      @(negedge clk);
      chk("ready_held_off", {31'd0, o_binReady}, 0);
      sync();
    end
    i_binValid = 1'b0;
    frame_start();
    @(negedge clk);
    chk("ready_after_swap", {31'd0, o_binReady}, 1);
    sync();
    rd(200);
    rd(0);
    drain();

    // Random frames, one short so stale bins remain in the back bank
    for (int r = 0; r < 3; r++) begin
      make_frame((r == 2) ? $urandom_range(100, 900) : BINS, 2, 8'd0);
      send_frame(1, 0);
      frame_start();
      rd(BINS - 1);
      rd_rand(6);
      drain();
    end

    // Overrun: 1030 beats without last, then last
    @(negedge clk);
    chk("overrun_before", {31'd0, o_overrun}, 32'(m_overrun));
    sync();
    make_frame(BINS + 7, 2, 8'd0);
    send_frame(1, 0);
    @(negedge clk);
    chk("overrun_after", {31'd0, o_overrun}, 32'(m_overrun));
    sync();
    frame_start();
    rd(BINS - 1);
    rd(0);
    rd(512);
    drain();

    // Last beat and frame start in the same cycle
    make_frame(BINS, 2, 8'd0);
    send_frame(1, 1);
    @(negedge clk);
    chk("simul_ready_low", {31'd0, o_binReady}, 0);
    sync();
    @(negedge clk);
    chk("simul_ready_high", {31'd0, o_binReady}, 1);
    sync();
    rd(BINS - 1);
    rd_rand(4);
    drain();

    // Reset during beat 300
    make_frame(300, 2, 8'd0);
    send_frame(0, 0);
    i_rst_n = 1'b0;
    sync();
    m_reset();
    chk_reset_outputs("midrst");
    i_rst_n = 1'b1;
    sync();

    // Decay: 0x80 frame, then zero frames; bin 5 walks 80,80,7F,7F,7E
    make_frame(BINS, 0, 8'h80);
    send_frame(1, 0);
    frame_start();
    rd(5);
    rd_rand(2);
    drain();
    for (int r = 0; r < 4; r++) begin
      make_frame(BINS, 0, 8'h00);
      send_frame(1, 0);
      frame_start();
      rd(5);
      rd_rand(2);
      drain();
    end

    // Saturation: peaks cleared to 0 must not wrap under decay
    pulse_clr();
    for (int r = 0; r < 4; r++) begin
      make_frame(BINS, 0, 8'h00);
      send_frame(1, 0);
      frame_start();
      rd(5);
      rd_rand(2);
      drain();
    end

    // Peak clear with a 0x05 frame
    pulse_clr();
    make_frame(BINS, 0, 8'h05);
    send_frame(1, 0);
    frame_start();
    rd(5);
    rd_rand(8);
    drain();

    chk("sb_empty", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
